// File: rtl/mul_pkg.sv
// Shared constants and types for the shared 24x24 multiply controller.
package mul_pkg;

   localparam int unsigned MUL_W     = 24;
   localparam int unsigned MUL_CNT_W = 5;
   localparam int unsigned ID_W      = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef logic [ID_W-1:0] id_t;

   function automatic logic is_zero_op(input logic [MUL_W-1:0] a, input logic [MUL_W-1:0] b);
      return (a == '0) || (b == '0);
   endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Request/response bundle between the two requesters, the consumer and the shared multiplier.
interface mul_share_ctrl_if;
   import mul_pkg::*;

   logic               req0_valid;
   logic               req0_ready;
   logic [MUL_W-1:0]   req0_a;
   logic [MUL_W-1:0]   req0_b;
   logic               req1_valid;
   logic               req1_ready;
   logic [MUL_W-1:0]   req1_a;
   logic [MUL_W-1:0]   req1_b;
   logic               rsp_valid;
   logic               rsp_ready;
   id_t                rsp_id;
   logic [2*MUL_W-1:0] rsp_prod;

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod
   );

endinterface

// File: rtl/mul_seq_core.sv
// Iterative shift-add unsigned multiplier datapath: one partial-product step per step_i cycle.
module mul_seq_core
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_W,
   parameter int unsigned CNT_W = MUL_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               zero_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] prod_o,
   output logic [CNT_W-1:0]   count_o
);

   logic [WIDTH-1:0]   a_q,     a_d;
   logic [WIDTH-1:0]   b_q,     b_d;
   logic [2*WIDTH-1:0] prod_q,  prod_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH:0]     sum_c;

   // Zero-operand loads skip the operand registers; the product is already known to be 0.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      count_d = count_q;
      sum_c   = {1'b0, {WIDTH{b_q[0]}} & a_q} + {1'b0, prod_q[2*WIDTH-1:WIDTH]};
      if (load_i) begin
         prod_d  = '0;
         count_d = CNT_W'(WIDTH);
         if (!zero_i) begin
            a_d = a_i;
            b_d = b_i;
         end
      end else if (step_i) begin
         prod_d  = {sum_c, prod_q[WIDTH-1:1]};
         b_d     = b_q >> 1;
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         count_q <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         count_q <= count_d;
      end
   end

   assign prod_o  = prod_q;
   assign count_o = count_q;

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing of one iterative multiplier between two requesters with a held result port.
module mul_share_ctrl
   import mul_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   mul_share_ctrl_if.slave        bus,
   output logic                   busy
);

   state_e               state_q;
   id_t                  last_grant_q;
   logic                 rsp_valid_q;
   id_t                  rsp_id_q;
   id_t                  grant_id_c;
   logic                 accept_c;
   logic                 zero_c;
   logic [MUL_W-1:0]     op_a_c;
   logic [MUL_W-1:0]     op_b_c;
   logic [2*MUL_W-1:0]   prod;
   logic [MUL_CNT_W-1:0] count;

   // Arbiter: ties go to the requester that did not win last time.
   always_comb begin
      grant_id_c = id_t'(0);
      if (bus.req0_valid && bus.req1_valid) begin
         grant_id_c = ~last_grant_q;
      end else if (bus.req1_valid) begin
         grant_id_c = id_t'(1);
      end
      accept_c = rst_n && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
      op_a_c   = (grant_id_c == id_t'(1)) ? bus.req1_a : bus.req0_a;
      op_b_c   = (grant_id_c == id_t'(1)) ? bus.req1_b : bus.req0_b;
      zero_c   = is_zero_op(op_a_c, op_b_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= id_t'(1);
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= id_t'(0);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  last_grant_q <= grant_id_c;
                  rsp_id_q     <= grant_id_c;
                  if (zero_c) begin
                     state_q     <= ST_DONE;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (count == MUL_CNT_W'(1)) begin
                  state_q     <= ST_DONE;
                  rsp_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   mul_seq_core #(
      .WIDTH (MUL_W),
      .CNT_W (MUL_CNT_W)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (accept_c),
      .zero_i  (zero_c),
      .step_i  (state_q == ST_BUSY),
      .a_i     (op_a_c),
      .b_i     (op_b_c),
      .prod_o  (prod),
      .count_o (count)
   );

   assign bus.req0_ready = accept_c && (grant_id_c == id_t'(0));
   assign bus.req1_ready = accept_c && (grant_id_c == id_t'(1));
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_prod   = prod;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed and randomized checks of the shared multiplier controller.
module tb_mul_share_ctrl;
   import mul_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   checks = 0;
   int   errors = 0;
   logic [47:0] q0[$];
   logic [47:0] q1[$];

   always #5 clk = ~clk;

   mul_share_ctrl_if bus();

   mul_share_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   task automatic drive_idle();
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp_ready  = 1'b0;
   endtask

   // Present operands on one port, return once the accept edge has passed (at a negedge).
   task automatic issue(input int id, input logic [23:0] a, input logic [23:0] b, output bit ok);
      ok = 1'b0;
      if (id == 0) begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
      else begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
      #1;
      for (int i = 0; i < 200; i++) begin
         if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL issue_timeout id=%0d got ready=0 exp ready=1", id); end
      @(negedge clk);
      if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 100) begin @(negedge clk); lat++; end
      checks++;
      if (!bus.rsp_valid) begin errors++; $display("FAIL rsp_timeout got rsp_valid=0 exp 1"); end
   endtask

   task automatic consume();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL consume_clear got rsp_valid=%b exp 0", bus.rsp_valid); end
   endtask

   task automatic test_reset();
      bit ok; int lat;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; #1;
      checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b exp 0", bus.req0_ready); end
      checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b exp 0", bus.req1_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (bus.rsp_prod !== 48'h0) begin errors++; $display("FAIL rst_prod got %h exp 0", bus.rsp_prod); end
      checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL rst_id got %b exp 0", bus.rsp_id); end
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      @(negedge clk);
      issue(1, 24'd7, 24'd9, ok);
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midbusy got busy=%b exp 1", busy); end
      rst_n = 1'b0; #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b exp 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 24'd3, 24'd5, ok);
      wait_rsp(lat);
      checks++; if (lat != 24) begin errors++; $display("FAIL post_rst_latency got %0d exp 24", lat); end
      checks++; if (bus.rsp_prod !== 48'd15) begin errors++; $display("FAIL post_rst_prod got %h exp f", bus.rsp_prod); end
      consume();
   endtask

   task automatic test_single();
      bit ok; int lat;
      issue(0, 24'h000003, 24'h000005, ok);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
      wait_rsp(lat);
      checks++; if (lat != 24) begin errors++; $display("FAIL single_latency got %0d exp 24", lat); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_prod !== 48'd15) begin
            errors++;
            $display("FAIL single_hold%0d got v=%b id=%b prod=%h exp v=1 id=0 prod=f", i, bus.rsp_valid, bus.rsp_id, bus.rsp_prod);
         end
         if (i < 3) @(negedge clk);
      end
      consume();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b exp 0", busy); end
   endtask

   task automatic test_zero();
      bit ok; int lat;
      issue(0, 24'h000000, 24'h123456, ok);
      wait_rsp(lat);
      checks++; if (lat != 0) begin errors++; $display("FAIL zero_latency got %0d exp 0", lat); end
      checks++; if (bus.rsp_prod !== 48'h0) begin errors++; $display("FAIL zero_prod got %h exp 0", bus.rsp_prod); end
      checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL zero_id got %b exp 0", bus.rsp_id); end
      consume();
   endtask

   task automatic test_max();
      bit ok; int lat;
      issue(1, 24'hFFFFFF, 24'hFFFFFF, ok);
      wait_rsp(lat);
      checks++; if (bus.rsp_prod !== 48'hFFFFFE000001) begin errors++; $display("FAIL max_prod got %h exp fffffe000001", bus.rsp_prod); end
      checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL max_id got %b exp 1", bus.rsp_id); end
      consume();
   endtask

   task automatic test_contention();
      logic        exp_id [4];
      logic [47:0] exp_p  [4];
      logic        gid;
      bit          seen;
      int          lat;
      exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_p  = '{48'h33, 48'h2100, 48'h36, 48'h2121};
      bus.req0_a = 24'h11;  bus.req0_b = 24'h3;  bus.req0_valid = 1'b1;
      bus.req1_a = 24'h100; bus.req1_b = 24'h21; bus.req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         for (int i = 0; i < 200; i++) begin
            if (bus.req0_ready || bus.req1_ready) begin seen = 1'b1; break; end
            @(negedge clk); #1;
         end
         gid = bus.req1_ready;
         checks++;
         if (!seen || (bus.req0_ready && bus.req1_ready) || gid !== exp_id[k]) begin
            errors++;
            $display("FAIL cont_grant%0d got r0=%b r1=%b exp id=%b", k, bus.req0_ready, bus.req1_ready, exp_id[k]);
         end
         @(negedge clk);
         if (gid) bus.req1_a = 24'h101; else bus.req0_a = 24'h12;
         wait_rsp(lat);
         checks++;
         if (bus.rsp_id !== exp_id[k] || bus.rsp_prod !== exp_p[k]) begin
            errors++;
            $display("FAIL cont_rsp%0d got id=%b prod=%h exp id=%b prod=%h", k, bus.rsp_id, bus.rsp_prod, exp_id[k], exp_p[k]);
         end
         consume();
         #1;
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
   endtask

   task automatic rand_driver(input int id, input int n);
      for (int i = 0; i < n; i++) begin
         logic [23:0] a;
         logic [23:0] b;
         bit ok;
         a = 24'($urandom);
         b = 24'($urandom);
         if ($urandom_range(0, 15) == 0) a = '0;
         if ($urandom_range(0, 15) == 0) b = '0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (id == 0) begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
         else begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
         #1;
         ok = 1'b0;
         for (int w = 0; w < 2000; w++) begin
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin ok = 1'b1; break; end
            @(negedge clk); #1;
         end
         if (!ok) begin
            checks++; errors++;
            $display("FAIL rand_accept_timeout id=%0d op=%0d got ready=0 exp 1", id, i);
            return;
         end
         if (id == 0) q0.push_back(48'(a) * 48'(b)); else q1.push_back(48'(a) * 48'(b));
         @(negedge clk);
         if (id == 0) begin bus.req0_valid = 1'b0; bus.req0_a = 24'($urandom); bus.req0_b = 24'($urandom); end
         else begin bus.req1_valid = 1'b0; bus.req1_a = 24'($urandom); bus.req1_b = 24'($urandom); end
      end
   endtask

   task automatic rand_consumer(input int n);
      int got = 0;
      int cyc = 0;
      logic [47:0] exp_p;
      while (got < n && cyc < 45000) begin
         @(negedge clk); #1;
         cyc++;
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         if (bus.req0_ready && bus.req1_ready) begin
            checks++; errors++;
            $display("FAIL rand_both_ready got r0=1 r1=1 exp at most one");
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if ((bus.rsp_id == 1'b0 && q0.size() == 0) || (bus.rsp_id == 1'b1 && q1.size() == 0)) begin
               errors++;
               $display("FAIL rand_extra_rsp got id=%b with no pending op exp none", bus.rsp_id);
            end else begin
               exp_p = (bus.rsp_id == 1'b0) ? q0.pop_front() : q1.pop_front();
               if (bus.rsp_prod !== exp_p) begin
                  errors++;
                  $display("FAIL rand_prod#%0d got %h exp %h id=%b", got, bus.rsp_prod, exp_p, bus.rsp_id);
               end
            end
            got++;
         end
      end
      bus.rsp_ready = 1'b0;
      checks++; if (got != n) begin errors++; $display("FAIL rand_count got %0d exp %0d", got, n); end
      checks++; if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL rand_pending got %0d exp 0", q0.size() + q1.size()); end
   endtask

   task automatic test_random();
      fork
         rand_driver(0, 500);
         rand_driver(1, 500);
         rand_consumer(1000);
      join
   endtask

   initial begin
      drive_idle();
      repeat (2) @(negedge clk);
      test_reset();
      test_single();
      test_zero();
      test_max();
      test_contention();
      @(negedge clk);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
